// File: rtl/seg_bcd_display.sv
// seg_bcd_display
//   Sequential binary-to-decimal display driver. A value of N bits (optionally
//   two's-complement) is converted to D BCD digits by a shift-add-3
//   (double-dabble) engine and shown on active-low 7-segment digits plus a
//   sign digit. Conversion takes N cycles in CONV, then one UPD cycle
//   registers the display. A one-deep pending buffer captures loads that
//   arrive while a conversion is in flight.
//
//   Optional feature macro: SEG_LZ_BLANK_EN enables leading-zero blanking.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   value      binary value to display (N bits)
//   is_signed  treat value as two's-complement (sampled with value)
//   load       request a conversion
//   busy       high while the conversion engine is shifting
//   done       one-cycle pulse when the display outputs update
//   ovf        last displayed magnitude exceeded 10^D-1
//   segs       D digits, digit k at [7k+6:7k], k=0 is units (active-low a..g)
//   sign       sign digit (dash for negative, blank otherwise)
module seg_bcd_display #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   value,
  input  logic           is_signed,
  input  logic           load,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic [7*D-1:0] segs,
  output logic [6:0]     sign
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [N-1:0]     pend_val_q, pend_val_d;
  logic             pend_sgn_q, pend_sgn_d;
  logic [N-1:0]     mag_q, mag_d;
  logic             neg_q, neg_d;
  logic [4*D-1:0]   acc_q, acc_d;
  logic             aovf_q, aovf_d;
  logic [7*D-1:0]   segs_q, segs_d;
  logic [6:0]       sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [N-1:0]     src_val;
  logic             src_sgn;
  logic [4*D-1:0]   acc_corr;
  logic [7*D-1:0]   disp_segs;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Magnitude in N unsigned bits; the most negative value maps to 2^(N-1),
  // which still fits because the result is read as unsigned.
  function automatic logic [N-1:0] abs_mag(input logic [N-1:0] v, input logic s);
    if (s && v[N-1]) abs_mag = (~v) + N'(1);
    else             abs_mag = v;
  endfunction

  function automatic logic [4*D-1:0] add3(input logic [4*D-1:0] a);
    add3 = a;
    for (int k = 0; k < D; k++) begin
      if (a[4*k +: 4] > 4'd4) add3[4*k +: 4] = a[4*k +: 4] + 4'd3;
    end
  endfunction

  // Conversion source: live inputs when load is asserted, otherwise the
  // pending entry (only consulted when leaving UPD).
  always_comb begin
    src_val  = load ? value     : pend_val_q;
    src_sgn  = load ? is_signed : pend_sgn_q;
    acc_corr = add3(acc_q);
  end

  // Display image of the finished accumulator.
`ifdef SEG_LZ_BLANK_EN
  logic lead;
`endif
  always_comb begin
    disp_segs = '0;
`ifdef SEG_LZ_BLANK_EN
    lead = 1'b1;
`endif
    for (int k = D - 1; k >= 0; k--) begin
      if (aovf_q) begin
        disp_segs[7*k +: 7] = 7'h3F;
      end else begin
        disp_segs[7*k +: 7] = seg7(acc_q[4*k +: 4]);
`ifdef SEG_LZ_BLANK_EN
        // Blank zeros above the most significant nonzero digit; units always shown.
        if (lead && (k != 0) && (acc_q[4*k +: 4] == 4'd0)) disp_segs[7*k +: 7] = 7'h7F;
        else lead = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    pend_sgn_d = pend_sgn_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    aovf_d     = aovf_q;
    segs_d     = segs_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          neg_d   = is_signed & value[N-1];
          mag_d   = abs_mag(value, is_signed);
          acc_d   = '0;
          aovf_d  = 1'b0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (load) begin
          pend_vld_d = 1'b1;
          pend_val_d = value;
          pend_sgn_d = is_signed;
        end
        // A 1 leaving the top digit means the magnitude is already >= 10^D;
        // the flag is sticky because the remaining shifts only grow it.
        aovf_d = aovf_q | acc_corr[4*D-1];
        acc_d  = {acc_corr[4*D-2:0], mag_q[N-1]};
        mag_d  = {mag_q[N-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = UPD;
      end
      UPD: begin
        done_d = 1'b1;
        ovf_d  = aovf_q;
        segs_d = disp_segs;
        sign_d = neg_q ? 7'h3F : 7'h7F;
        if (load || pend_vld_q) begin
          // A live load supersedes whatever is pending.
          pend_vld_d = 1'b0;
          neg_d      = src_sgn & src_val[N-1];
          mag_d      = abs_mag(src_val, src_sgn);
          acc_d      = '0;
          aovf_d     = 1'b0;
          cnt_d      = '0;
          state_d    = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      segs_q     <= '1;
      sign_q     <= 7'h7F;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      segs_q     <= segs_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // Datapath registers are always initialised at conversion start.
  always_ff @(posedge clk) begin
    pend_val_q <= pend_val_d;
    pend_sgn_q <= pend_sgn_d;
    mag_q      <= mag_d;
    neg_q      <= neg_d;
    acc_q      <= acc_d;
    aovf_q     <= aovf_d;
  end

  assign busy = (state_q == CONV);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign segs = segs_q;
  assign sign = sign_q;

endmodule

// File: tb/tb_seg_bcd_display.sv
module tb_seg_bcd_display;

  logic        clk;
  logic        reset;
  logic [7:0]  value;
  logic        is_signed;
  logic        load;
  logic        load2;
  logic        busy, done, ovf;
  logic        busy2, done2, ovf2;
  logic [20:0] segs;
  logic [13:0] segs2;
  logic [6:0]  sign, sign2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [20:0] segs;
    logic [6:0]  sign;
    logic        ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  seg_bcd_display #(.N(8), .D(3)) u_dut (
    .clk(clk), .reset(reset), .value(value), .is_signed(is_signed), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .segs(segs), .sign(sign)
  );

  seg_bcd_display #(.N(8), .D(2)) u_dut2 (
    .clk(clk), .reset(reset), .value(value), .is_signed(is_signed), .load(load2),
    .busy(busy2), .done(done2), .ovf(ovf2), .segs(segs2), .sign(sign2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  function automatic logic [20:0] model_segs(input int mag, input int nd);
    logic [20:0] r;
    int dig;
    bit lead;
    r = '0;
    lead = 1'b1;
    for (int k = nd - 1; k >= 0; k--) begin
      if (mag >= 10 ** nd) begin
        r[7*k +: 7] = 7'h3F;
      end else begin
        dig = (mag / (10 ** k)) % 10;
        r[7*k +: 7] = enc(dig);
`ifdef SEG_LZ_BLANK_EN
        if (lead && dig == 0 && k > 0) r[7*k +: 7] = 7'h7F;
        else lead = 1'b0;
`endif
      end
    end
    return r;
  endfunction

  // Push expectation then drive one load pulse; returns at the negedge after E0.
  task automatic load_exp(input int sel, input logic [7:0] v, input logic s);
    exp_t e;
    int mag;
    int nd;
    bit neg;
    nd  = (sel == 0) ? 3 : 2;
    neg = s && v[7];
    mag = neg ? 256 - int'(v) : int'(v);
    e.segs = model_segs(mag, nd);
    e.sign = neg ? 7'h3F : 7'h7F;
    e.ovf  = (mag >= 10 ** nd);
    if (sel == 0) q1.push_back(e); else q2.push_back(e);
    value = v;
    is_signed = s;
    if (sel == 0) load = 1'b1; else load2 = 1'b1;
    @(negedge clk);
    load = 1'b0;
    load2 = 1'b0;
  endtask

  // Wait (bounded) for done; n0 = edges already elapsed since the load edge.
  task automatic wait_done(input int sel, input string tag, input int n0, input int lat);
    int n;
    exp_t e;
    logic d;
    n = n0;
    d = (sel == 0) ? done : done2;
    while (!d && n < lat + 20) begin
      @(negedge clk);
      n++;
      d = (sel == 0) ? done : done2;
      if (n == 1 || n == 7) chk({tag, "_busy"}, (sel == 0) ? busy : busy2, 1);
    end
    chk({tag, "_latency"}, n, lat);
    if (d) begin
      chk({tag, "_queued"}, ((sel == 0) ? q1.size() : q2.size()) != 0, 1);
      if ((sel == 0 && q1.size() != 0) || (sel == 1 && q2.size() != 0)) begin
        e = (sel == 0) ? q1.pop_front() : q2.pop_front();
        chk({tag, "_segs"}, (sel == 0) ? 32'(segs) : 32'(segs2), 32'(e.segs));
        chk({tag, "_sign"}, (sel == 0) ? sign : sign2, e.sign);
        chk({tag, "_ovf"},  (sel == 0) ? ovf : ovf2, e.ovf);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, (sel == 0) ? done : done2, 0);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b0;
    value = '0;
    is_signed = 1'b0;
    load = 1'b0;
    load2 = 1'b0;
    #12;
    chk("rst_segs", segs, 21'h1FFFFF);
    chk("rst_segs2", segs2, 14'h3FFF);
    chk("rst_sign", sign, 7'h7F);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    load_exp(0, 8'hFF, 1'b0); wait_done(0, "u_ff", 0, 9);
    load_exp(0, 8'h80, 1'b1); wait_done(0, "s_80", 0, 9);
    load_exp(0, 8'hFF, 1'b1); wait_done(0, "s_ff", 0, 9);
    load_exp(0, 8'h00, 1'b1); wait_done(0, "s_00", 0, 9);
    load_exp(0, 8'h7F, 1'b1); wait_done(0, "s_7f", 0, 9);

    load_exp(1, 8'd100, 1'b0); wait_done(1, "d2_100", 0, 9);
    load_exp(1, 8'd99, 1'b0);  wait_done(1, "d2_99", 0, 9);

    // Pending buffer: 12 at E0, 34 at E3, 56 at E5; 34 is overwritten.
    load_exp(0, 8'd12, 1'b0);
    repeat (2) @(negedge clk);
    value = 8'd34; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    value = 8'd56; load = 1'b1;
    begin
      exp_t e;
      e.segs = model_segs(56, 3); e.sign = 7'h7F; e.ovf = 1'b0;
      q1.push_back(e);
    end
    @(negedge clk);
    load = 1'b0;
    wait_done(0, "pend12", 5, 9);
    wait_done(0, "pend56", 1, 9);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("pend_no_third_done", cnt, 0);
    chk("pend_idle_busy", busy, 0);
    chk("pend_queue_empty", q1.size(), 0);

    // Reset in the middle of a conversion.
    value = 8'h55; is_signed = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_segs", segs, 21'h1FFFFF);
    chk("abort_sign", sign, 7'h7F);
    chk("abort_busy", busy, 0);
    chk("abort_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    load_exp(0, 8'h00, 1'b0); wait_done(0, "zero", 0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_bcd_display.md
# seg_bcd_display

Parametrised sequential binary-to-decimal display driver for the picoMIPS board outputs. It takes an N-bit value (the CPU `display` bus), optionally treats it as two's-complement, and converts it to D decimal digits with an iterative shift-add-3 (double-dabble) engine. The results drive active-low 7-segment digits plus a sign digit. It replaces the fixed 3-digit combinational decoder with configurable width and depth, a load/busy/done handshake, a one-deep pending buffer, and overflow indication.

## Interface
- `N`, 8, input value width (≥2)
- `D`, 3, number of decimal digits displayed (≥1)
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `value` in N: binary value to display
- `is_signed` in 1: 1 = `value` is two's-complement; sampled with `value`
- `load` in 1: request conversion of `value`/`is_signed` at this edge
- `busy` out 1: conversion in progress
- `done` out 1: one-cycle pulse when segment outputs update
- `ovf` out 1: last displayed magnitude exceeded 10^D−1
- `segs` out 7·D: digit k occupies bits [7k+6:7k]; k=0 is the units digit
- `sign` out 7: sign digit

## Operation
- Segment encoding is active-low: bit0 = a … bit6 = g.
  - Digits 0–9: 40,79,24,30,19,12,02,78,00,10 (hex).
  - Blank = 7F; dash (g only) = 3F.
- States:
  - IDLE: waits for a load.
  - CONV: runs for exactly N cycles.
  - UPD: lasts exactly 1 cycle.
- IDLE with `load`=1: capture the sign flag as `is_signed & value[N-1]` and the magnitude as |value| in N unsigned bits. −2^(N−1) gives magnitude 2^(N−1). Clear the BCD accumulator, then go to CONV.
- CONV, each cycle: add 3 to every BCD nibble ≥5, then shift the magnitude MSB into the accumulator LSB. After N shifts, go to UPD.
- Accumulator width is 4·D plus overflow detection. `ovf` is set when the magnitude is ≥10^D, including carries out of the top digit.
- UPD, registered outputs:
  - If ovf: all `segs` digits = dash.
  - Otherwise: digit codes per the encoding above.
  - `sign` = 3F if the sign flag is set, else 7F.
  - `done`=1.
- Pending buffer (one entry):
  - `load` while in CONV or UPD stores `value`/`is_signed` in the pending register and sets pending-valid; a newer load overwrites an older one.
- Leaving UPD:
  - If `load`=1 that cycle, start CONV with the live inputs and discard pending.
  - Else if pending-valid, start CONV with the pending value and clear pending-valid.
  - Else go to IDLE.
- `busy` = 1 in CONV only; it is 0 in UPD and IDLE.
- Outputs hold their last values between conversions.

## Timing
- Reset (asynchronous, active-low): state IDLE, pending cleared.
  - `segs` all 7F, `sign`=7F, `busy`=0, `done`=0, `ovf`=0.
- Reset asserted mid-conversion aborts immediately; no `done` is produced.
- `load` is sampled at edge E0. `busy` is high after E1 through edge E(N), giving N cycles.
- Outputs, `ovf` and `done` update at edge E(N+1), so load-to-display latency is N+1 cycles.
- `done` is high for exactly one cycle unless back-to-back. In that case the next `done` follows N+1 cycles later, so throughput is one conversion per N+1 cycles.
- `load` held high continuously: one conversion per N+1 cycles, each using the input present at the UPD cycle.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - Every digit above the most significant nonzero digit shows 7F.
  - Digit 0 is always shown, so value 0 displays "0".
  - Overflow dashes are never blanked.
- Not defined: all D digits are always shown, including leading zeros (e.g. "007").

## Test plan
- N=8, D=3, reset released, unsigned `value`=FF → after 9 cycles `segs`={24,12,12} (2,5,5), `sign`=7F, `ovf`=0, `done` pulse 1 cycle.
- `is_signed`=1, `value`=80 → digits 1,2,8, `sign`=3F. `value`=FF → digits 0,0,1 without the macro; 7F,7F,79 with `SEG_LZ_BLANK_EN`.
- D=2, unsigned `value`=100 → `ovf`=1, both digits 3F. Then `value`=99 → `ovf`=0, digits 9,9.
- Load 12 at E0, then loads 34 at E3 and 56 at E5 (during CONV) → display 12 at E9, then 56 at E18 (34 discarded), then IDLE. Exactly two `done` pulses.
- Assert `reset` low at E4 of a conversion → outputs immediately 7F/0, no `done`. Release, load 0 → digits 0,0,0 (or 7F,7F,40 with the macro).
- `value`=00, `is_signed`=1 → `sign`=7F (no negative zero). `value`=7F signed → digits 1,2,7, `sign`=7F.
